axi_write_router: RTL and testbench
===================================

Name: axi_write_router

Overview:
- Sits directly downstream of the write-address (AW) arbiter on the AXI crossbar write path.
- Accepts one arbitrated AW transfer and decodes its address to slave S0, slave S1 or the default (decode-error) slave SD.
- Registers the AW onto the selected slave port and steers W beats from the owning master to that slave until the burst completes.
- Allows one write burst in flight at a time; the B channel is out of scope (handled by the response block).

Parameters:
- S0_BASE, 16'h0000, addr[31:16] value selecting S0
- S1_BASE, 16'h0001, addr[31:16] value selecting S1
- IDS_W, 8, width of extended ID: {master[3:0], ID[3:0]}

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- I_IDS  in  8  arbitrated AW extended ID; bits [7:4] give the master (0 or 1)
- I_Addr  in  32  AW address
- I_Len  in  4  burst length minus 1
- I_Size  in  3  beat size
- I_Burst  in  2  burst type
- I_Valid  in  1  AW valid from arbiter
- I_Ready  out  1  AW ready to arbiter
- M0_WDATA / M1_WDATA  in  32  W data from master 0 / 1
- M0_WSTRB / M1_WSTRB  in  4  byte strobes
- M0_WLAST / M1_WLAST  in  1  master-asserted last beat
- M0_WVALID / M1_WVALID  in  1  W valid
- M0_WREADY / M1_WREADY  out  1  W ready
- Sx_AWID, Sx_AWADDR, Sx_AWLEN, Sx_AWSIZE, Sx_AWBURST, Sx_AWVALID  out  8/32/4/3/2/1  AW to slave x, for x in {0, 1, D}
- Sx_AWREADY  in  1  AW ready from slave x
- Sx_WDATA, Sx_WSTRB, Sx_WLAST, Sx_WVALID  out  32/4/1/1  W to slave x
- Sx_WREADY  in  1  W ready from slave x
- err_wlast  out  1  sticky flag: master WLAST disagreed with the internal beat count

Behaviour:
- Reset (async): state=IDLE and all registers cleared. I_Ready=0, all Sx_AWVALID=0, Sx_WVALID=0, Mx_WREADY=0, err_wlast=0. All slave data outputs are 0.
- States: IDLE, AW_FWD, W_FWD.
- IDLE
  - I_Ready=1.
  - On I_Valid&I_Ready, capture IDS, Addr, Len, Size, Burst, master=I_IDS[7:4][0] and sel=decode(Addr); go to AW_FWD.
- Decode:
  - addr[31:16]==S0_BASE selects S0.
  - addr[31:16]==S1_BASE selects S1.
  - Any other value selects SD.
- AW_FWD
  - Sel_AWVALID=1, driven from registers with no combinational path from I_*. The first AWVALID appears 1 cycle after the upstream handshake.
  - I_Ready=0.
  - On Sel_AWREADY, go to W_FWD and clear beat_cnt to 0.
  - W is blocked in this state: Mx_WREADY=0 and Sx_WVALID=0.
- W_FWD
  - Combinational mux from the owning master: Sel_WDATA/WSTRB/WVALID come from M[master]; M[master]_WREADY=Sel_WREADY.
  - The non-owning master sees WREADY=0; non-selected slaves see WVALID=0 and data 0.
  - Sel_WLAST is driven as (beat_cnt==Len_reg); the master's WLAST is ignored for routing.
  - On each beat handshake, beat_cnt increments (4-bit, no wrap beyond Len).
  - If M_WLAST != (beat_cnt==Len_reg) on a handshake, set err_wlast; it clears only on reset.
  - On the handshake where beat_cnt==Len_reg, return to IDLE. The next AW can be accepted in the following cycle, so AW-to-AW spacing is at least Len+3 cycles.
- Len=0 means a single beat; WLAST=1 on the first beat.
- WVALID deasserted mid-burst: hold state and beat_cnt, no timeout.
- Sel_AWREADY held low indefinitely: stay in AW_FWD with AWVALID and payload stable (AXI rule).
- I_Valid asserted outside IDLE: ignored (I_Ready=0); the arbiter holds it.
- rst asserted mid-burst: immediate return to IDLE, with all valids and readies low in the same cycle. Beats of the aborted burst are not replayed.
- Master field values above 1 (IDS[7:4]>1): treated as master 1 (bit 0 only).

Decomposition:
- Shared package axi_pkg holds:
  - width constants: AXI_ID_BITS=4, AXI_IDS_BITS=8, ADDR 32, LEN 4, SIZE 3, DATA 32, STRB 4
  - slave-select enum {SEL_S0, SEL_S1, SEL_SD}
  - router state enum {IDLE, AW_FWD, W_FWD}
  - region base constants
- One sub-module, axi_addr_decoder: purely combinational, 32-bit address in, slave-select enum out. It is reused by the read-path router.

Test Plan:
- AW Addr=0x0000_0040, IDS=0x03, Len=3; M0 streams 4 beats with WLAST on beat 4 -> S0_AWVALID 1 cycle after handshake with AWID=0x03; S0 receives 4 beats, WLAST only on beat 4; err_wlast=0; state back to IDLE.
- AW Addr=0x0001_0010, IDS=0x12, Len=0; M1 one beat with WDATA=0xDEADBEEF -> S1 gets AWLEN=0 and one beat with WLAST=1; M0_WREADY stays 0 throughout.
- AW Addr=0x8000_0000 -> routed to SD; S0 and S1 AWVALID/WVALID stay 0.
- S0_AWREADY held low 5 cycles -> AWVALID and payload stable for 5 cycles; I_Ready=0; no W accepted until the AW handshake.
- Len=3 with M0 asserting WLAST on beat 2 -> err_wlast=1 after beat 2; S0_WLAST still only on beat 4; err_wlast stays 1 after a following good burst.
- rst pulsed during beat 2 of a Len=7 burst -> all valids and readies 0 immediately; the next AW after reset is accepted from IDLE and routed correctly.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : axi_pkg
// Purpose  : Shared AXI crossbar definitions: channel widths, address-region
//            bases, slave-select and write-router state encodings.
// Revision : 1.0  initial release
//============================================================================
package axi_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_IDS_BITS   = 8;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = 4;

    // addr[31:16] values of the two mapped regions
    localparam logic [15:0] REGION_S0_BASE = 16'h0000;
    localparam logic [15:0] REGION_S1_BASE = 16'h0001;

    typedef enum logic [1:0] {
        SEL_S0 = 2'd0,
        SEL_S1 = 2'd1,
        SEL_SD = 2'd2
    } slave_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AW_FWD = 2'd1,
        W_FWD  = 2'd2
    } router_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_addr_decoder.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : axi_addr_decoder
// Purpose  : Combinational address decode to S0, S1 or the decode-error
//            slave SD, keyed on addr[31:16]. Shared by read and write paths.
// Ports    : addr (in, 32)  - transaction address
//            sel  (out)     - slave select
// Revision : 1.0  initial release
//============================================================================
module axi_addr_decoder
    import axi_pkg::*;
#(
    parameter logic [15:0] S0_BASE = REGION_S0_BASE,
    parameter logic [15:0] S1_BASE = REGION_S1_BASE
) (
    input  logic [AXI_ADDR_BITS-1:0] addr,
    output slave_sel_e               sel
);

    // Low address bits do not take part in region decode
    logic w_unused_low;
    assign w_unused_low = ^addr[15:0];

    always_comb begin
        sel = SEL_SD;
        if (addr[31:16] == S0_BASE) begin
            sel = SEL_S0;
        end else if (addr[31:16] == S1_BASE) begin
            sel = SEL_S1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_write_router.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : axi_write_router
// Purpose  : Takes one arbitrated AW, decodes it to S0/S1/SD, registers it
//            onto the selected slave AW port, then steers the owning
//            master's W beats to that slave until the burst completes.
//            One write burst in flight at a time.
// Ports    : clk, rst (async, active-high)
//            I_*       - arbitrated AW in, I_Ready back to arbiter
//            M0_W*/M1_W* - W channel from masters 0/1
//            S0_*/S1_*/SD_* - AW and W channels to slaves
//            err_wlast - sticky: master WLAST disagreed with beat count
// Revision : 1.0  initial release
//============================================================================
module axi_write_router
    import axi_pkg::*;
#(
    parameter logic [15:0] S0_BASE = REGION_S0_BASE,
    parameter logic [15:0] S1_BASE = REGION_S1_BASE,
    parameter int          IDS_W   = AXI_IDS_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDS_W-1:0]          I_IDS,
    input  logic [AXI_ADDR_BITS-1:0]  I_Addr,
    input  logic [AXI_LEN_BITS-1:0]   I_Len,
    input  logic [AXI_SIZE_BITS-1:0]  I_Size,
    input  logic [AXI_BURST_BITS-1:0] I_Burst,
    input  logic                      I_Valid,
    output logic                      I_Ready,
    input  logic [AXI_DATA_BITS-1:0]  M0_WDATA,
    input  logic [AXI_STRB_BITS-1:0]  M0_WSTRB,
    input  logic                      M0_WLAST,
    input  logic                      M0_WVALID,
    output logic                      M0_WREADY,
    input  logic [AXI_DATA_BITS-1:0]  M1_WDATA,
    input  logic [AXI_STRB_BITS-1:0]  M1_WSTRB,
    input  logic                      M1_WLAST,
    input  logic                      M1_WVALID,
    output logic                      M1_WREADY,
    output logic [IDS_W-1:0]          S0_AWID,
    output logic [AXI_ADDR_BITS-1:0]  S0_AWADDR,
    output logic [AXI_LEN_BITS-1:0]   S0_AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  S0_AWSIZE,
    output logic [AXI_BURST_BITS-1:0] S0_AWBURST,
    output logic                      S0_AWVALID,
    input  logic                      S0_AWREADY,
    output logic [AXI_DATA_BITS-1:0]  S0_WDATA,
    output logic [AXI_STRB_BITS-1:0]  S0_WSTRB,
    output logic                      S0_WLAST,
    output logic                      S0_WVALID,
    input  logic                      S0_WREADY,
    output logic [IDS_W-1:0]          S1_AWID,
    output logic [AXI_ADDR_BITS-1:0]  S1_AWADDR,
    output logic [AXI_LEN_BITS-1:0]   S1_AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  S1_AWSIZE,
    output logic [AXI_BURST_BITS-1:0] S1_AWBURST,
    output logic                      S1_AWVALID,
    input  logic                      S1_AWREADY,
    output logic [AXI_DATA_BITS-1:0]  S1_WDATA,
    output logic [AXI_STRB_BITS-1:0]  S1_WSTRB,
    output logic                      S1_WLAST,
    output logic                      S1_WVALID,
    input  logic                      S1_WREADY,
    output logic [IDS_W-1:0]          SD_AWID,
    output logic [AXI_ADDR_BITS-1:0]  SD_AWADDR,
    output logic [AXI_LEN_BITS-1:0]   SD_AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  SD_AWSIZE,
    output logic [AXI_BURST_BITS-1:0] SD_AWBURST,
    output logic                      SD_AWVALID,
    input  logic                      SD_AWREADY,
    output logic [AXI_DATA_BITS-1:0]  SD_WDATA,
    output logic [AXI_STRB_BITS-1:0]  SD_WSTRB,
    output logic                      SD_WLAST,
    output logic                      SD_WVALID,
    input  logic                      SD_WREADY,
    output logic                      err_wlast
);

    router_state_e              r_state;
    router_state_e              w_state_nxt;
    slave_sel_e                 r_sel;
    slave_sel_e                 w_dec_sel;
    logic [IDS_W-1:0]           r_ids;
    logic [AXI_ADDR_BITS-1:0]   r_addr;
    logic [AXI_LEN_BITS-1:0]    r_len;
    logic [AXI_SIZE_BITS-1:0]   r_size;
    logic [AXI_BURST_BITS-1:0]  r_burst;
    logic                       r_master;
    logic [AXI_LEN_BITS-1:0]    r_beat_cnt;
    logic                       r_err_wlast;

    logic [AXI_DATA_BITS-1:0]   w_m_wdata;
    logic [AXI_STRB_BITS-1:0]   w_m_wstrb;
    logic                       w_m_wlast;
    logic                       w_m_wvalid;
    logic                       w_sel_awready;
    logic                       w_sel_wready;
    logic                       w_last_beat;
    logic                       w_aw_take;
    logic                       w_aw_hs;
    logic                       w_w_hs;

    axi_addr_decoder #(
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_dec (
        .addr (I_Addr),
        .sel  (w_dec_sel)
    );

    assign w_m_wdata   = r_master ? M1_WDATA  : M0_WDATA;
    assign w_m_wstrb   = r_master ? M1_WSTRB  : M0_WSTRB;
    assign w_m_wlast   = r_master ? M1_WLAST  : M0_WLAST;
    assign w_m_wvalid  = r_master ? M1_WVALID : M0_WVALID;
    assign w_last_beat = (r_beat_cnt == r_len);

    always_comb begin
        case (r_sel)
            SEL_S0:  begin w_sel_awready = S0_AWREADY; w_sel_wready = S0_WREADY; end
            SEL_S1:  begin w_sel_awready = S1_AWREADY; w_sel_wready = S1_WREADY; end
            default: begin w_sel_awready = SD_AWREADY; w_sel_wready = SD_WREADY; end
        endcase
    end

    // The async reset forces IDLE, which would otherwise raise I_Ready while
    // rst is still asserted; gate it so nothing handshakes during reset.
    assign I_Ready   = (r_state == IDLE) && !rst;
    assign w_aw_take = (r_state == IDLE) && I_Valid;
    assign w_aw_hs   = (r_state == AW_FWD) && w_sel_awready;
    assign w_w_hs    = (r_state == W_FWD) && w_m_wvalid && w_sel_wready;
    assign err_wlast = r_err_wlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and all slave/master-facing outputs. Non-selected slaves
    // and the non-owning master see zeros throughout.
    always_comb begin
        w_state_nxt = r_state;
        M0_WREADY  = 1'b0;  M1_WREADY  = 1'b0;
        S0_AWID    = '0;    S0_AWADDR  = '0;  S0_AWLEN = '0;  S0_AWSIZE = '0;
        S0_AWBURST = '0;    S0_AWVALID = 1'b0;
        S0_WDATA   = '0;    S0_WSTRB   = '0;  S0_WLAST = 1'b0; S0_WVALID = 1'b0;
        S1_AWID    = '0;    S1_AWADDR  = '0;  S1_AWLEN = '0;  S1_AWSIZE = '0;
        S1_AWBURST = '0;    S1_AWVALID = 1'b0;
        S1_WDATA   = '0;    S1_WSTRB   = '0;  S1_WLAST = 1'b0; S1_WVALID = 1'b0;
        SD_AWID    = '0;    SD_AWADDR  = '0;  SD_AWLEN = '0;  SD_AWSIZE = '0;
        SD_AWBURST = '0;    SD_AWVALID = 1'b0;
        SD_WDATA   = '0;    SD_WSTRB   = '0;  SD_WLAST = 1'b0; SD_WVALID = 1'b0;

        case (r_state)
            IDLE: begin
                if (I_Valid) begin
                    w_state_nxt = AW_FWD;
                end
            end
            AW_FWD: begin
                // AW payload comes only from registers: no I_* to Sx path
                case (r_sel)
                    SEL_S0: begin
                        S0_AWVALID = 1'b1; S0_AWID = r_ids; S0_AWADDR = r_addr;
                        S0_AWLEN = r_len; S0_AWSIZE = r_size; S0_AWBURST = r_burst;
                    end
                    SEL_S1: begin
                        S1_AWVALID = 1'b1; S1_AWID = r_ids; S1_AWADDR = r_addr;
                        S1_AWLEN = r_len; S1_AWSIZE = r_size; S1_AWBURST = r_burst;
                    end
                    default: begin
                        SD_AWVALID = 1'b1; SD_AWID = r_ids; SD_AWADDR = r_addr;
                        SD_AWLEN = r_len; SD_AWSIZE = r_size; SD_AWBURST = r_burst;
                    end
                endcase
                if (w_aw_hs) begin
                    w_state_nxt = W_FWD;
                end
            end
            W_FWD: begin
                // WLAST comes from our own beat count, not the master's
                case (r_sel)
                    SEL_S0: begin
                        S0_WVALID = w_m_wvalid; S0_WDATA = w_m_wdata;
                        S0_WSTRB = w_m_wstrb; S0_WLAST = w_last_beat;
                    end
                    SEL_S1: begin
                        S1_WVALID = w_m_wvalid; S1_WDATA = w_m_wdata;
                        S1_WSTRB = w_m_wstrb; S1_WLAST = w_last_beat;
                    end
                    default: begin
                        SD_WVALID = w_m_wvalid; SD_WDATA = w_m_wdata;
                        SD_WSTRB = w_m_wstrb; SD_WLAST = w_last_beat;
                    end
                endcase
                if (r_master) begin
                    M1_WREADY = w_sel_wready;
                end else begin
                    M0_WREADY = w_sel_wready;
                end
                if (w_w_hs && w_last_beat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= SEL_S0;
            r_ids       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_master    <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_wlast <= 1'b0;
        end else begin
            if (w_aw_take) begin
                r_ids    <= I_IDS;
                r_addr   <= I_Addr;
                r_len    <= I_Len;
                r_size   <= I_Size;
                r_burst  <= I_Burst;
                // Only bit 0 of the master field matters: values >1 map to master 1
                r_master <= I_IDS[IDS_W-AXI_ID_BITS];
                r_sel    <= w_dec_sel;
            end
            if (w_aw_hs) begin
                r_beat_cnt <= '0;
            end
            if (w_w_hs) begin
                if (!w_last_beat) begin
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                end
                if (w_m_wlast != w_last_beat) begin
                    r_err_wlast <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_router.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_axi_write_router
// Purpose  : Self-checking bench for axi_write_router. Stimulus pushes the
//            expected slave-side AW and W transfers into queues; a monitor
//            pops and compares on every slave-side handshake.
// Revision : 1.0  initial release
//============================================================================
module tb_axi_write_router;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  I_IDS;
    logic [31:0] I_Addr;
    logic [3:0]  I_Len;
    logic [2:0]  I_Size;
    logic [1:0]  I_Burst;
    logic        I_Valid, I_Ready;
    logic [31:0] M0_WDATA, M1_WDATA;
    logic [3:0]  M0_WSTRB, M1_WSTRB;
    logic        M0_WLAST, M1_WLAST, M0_WVALID, M1_WVALID, M0_WREADY, M1_WREADY;
    logic [7:0]  S0_AWID, S1_AWID, SD_AWID;
    logic [31:0] S0_AWADDR, S1_AWADDR, SD_AWADDR;
    logic [3:0]  S0_AWLEN, S1_AWLEN, SD_AWLEN;
    logic [2:0]  S0_AWSIZE, S1_AWSIZE, SD_AWSIZE;
    logic [1:0]  S0_AWBURST, S1_AWBURST, SD_AWBURST;
    logic        S0_AWVALID, S1_AWVALID, SD_AWVALID;
    logic        S0_AWREADY, S1_AWREADY, SD_AWREADY;
    logic [31:0] S0_WDATA, S1_WDATA, SD_WDATA;
    logic [3:0]  S0_WSTRB, S1_WSTRB, SD_WSTRB;
    logic        S0_WLAST, S1_WLAST, SD_WLAST;
    logic        S0_WVALID, S1_WVALID, SD_WVALID;
    logic        S0_WREADY, S1_WREADY, SD_WREADY;
    logic        err_wlast;

    axi_write_router dut (
        .clk(clk), .rst(rst),
        .I_IDS(I_IDS), .I_Addr(I_Addr), .I_Len(I_Len), .I_Size(I_Size),
        .I_Burst(I_Burst), .I_Valid(I_Valid), .I_Ready(I_Ready),
        .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST),
        .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
        .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST),
        .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
        .S0_AWID(S0_AWID), .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN),
        .S0_AWSIZE(S0_AWSIZE), .S0_AWBURST(S0_AWBURST), .S0_AWVALID(S0_AWVALID),
        .S0_AWREADY(S0_AWREADY), .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB),
        .S0_WLAST(S0_WLAST), .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
        .S1_AWID(S1_AWID), .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN),
        .S1_AWSIZE(S1_AWSIZE), .S1_AWBURST(S1_AWBURST), .S1_AWVALID(S1_AWVALID),
        .S1_AWREADY(S1_AWREADY), .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB),
        .S1_WLAST(S1_WLAST), .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
        .SD_AWID(SD_AWID), .SD_AWADDR(SD_AWADDR), .SD_AWLEN(SD_AWLEN),
        .SD_AWSIZE(SD_AWSIZE), .SD_AWBURST(SD_AWBURST), .SD_AWVALID(SD_AWVALID),
        .SD_AWREADY(SD_AWREADY), .SD_WDATA(SD_WDATA), .SD_WSTRB(SD_WSTRB),
        .SD_WLAST(SD_WLAST), .SD_WVALID(SD_WVALID), .SD_WREADY(SD_WREADY),
        .err_wlast(err_wlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] aw_q[$];
    logic [63:0] w_q[$];
    int mon_nw;
    int mon_naw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_aw(input int s, input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [1:0] sl;
        sl = s[1:0];
        aw_q.push_back({13'd0, sl, id, addr, len, size, burst});
    endtask

    task automatic push_w(input int s, input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic [1:0] sl;
        sl = s[1:0];
        w_q.push_back({25'd0, sl, data, strb, last});
    endtask

    task automatic mon_aw(input int s, input logic v, input logic r, input logic [7:0] id,
                          input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        logic [1:0]  sl;
        logic [63:0] got;
        sl  = s[1:0];
        got = {13'd0, sl, id, addr, len, size, burst};
        if (v && r) begin
            if (aw_q.size() == 0) begin
                n_checks++;
                $display("FAIL aw_unexpected: got 0x%0h expected no AW", got);
            end else begin
                chk("aw_route", got, aw_q.pop_front());
            end
        end
    endtask

    task automatic mon_w(input int s, input logic v, input logic r, input logic [31:0] data,
                         input logic [3:0] strb, input logic last);
        logic [1:0]  sl;
        logic [63:0] got;
        sl  = s[1:0];
        got = {25'd0, sl, data, strb, last};
        if (v && r) begin
            if (w_q.size() == 0) begin
                n_checks++;
                $display("FAIL w_unexpected: got 0x%0h expected no W", got);
            end else begin
                chk("w_route", got, w_q.pop_front());
            end
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            mon_aw(0, S0_AWVALID, S0_AWREADY, S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST);
            mon_aw(1, S1_AWVALID, S1_AWREADY, S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST);
            mon_aw(2, SD_AWVALID, SD_AWREADY, SD_AWID, SD_AWADDR, SD_AWLEN, SD_AWSIZE, SD_AWBURST);
            mon_w(0, S0_WVALID, S0_WREADY, S0_WDATA, S0_WSTRB, S0_WLAST);
            mon_w(1, S1_WVALID, S1_WREADY, S1_WDATA, S1_WSTRB, S1_WLAST);
            mon_w(2, SD_WVALID, SD_WREADY, SD_WDATA, SD_WSTRB, SD_WLAST);
            mon_nw  = int'(S0_WVALID) + int'(S1_WVALID) + int'(SD_WVALID);
            mon_naw = int'(S0_AWVALID) + int'(S1_AWVALID) + int'(SD_AWVALID);
            if (mon_nw != 0)  chk("one_slave_wvalid", mon_nw, 1);
            if (mon_naw != 0) chk("one_slave_awvalid", mon_naw, 1);
        end
    end

    function automatic logic sel_awvalid(input int s);
        case (s)
            0:       return S0_AWVALID;
            1:       return S1_AWVALID;
            default: return SD_AWVALID;
        endcase
    endfunction

    // Called just after a rising edge; returns just after a rising edge
    task automatic send_aw(input logic [7:0] ids, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int s);
        logic ok;
        push_aw(s, ids, addr, len, size, burst);
        I_IDS = ids; I_Addr = addr; I_Len = len; I_Size = size; I_Burst = burst;
        I_Valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (I_Ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL aw_accept_timeout: I_Ready=0 required 1");
            I_Valid = 1'b0;
            return;
        end
        chk("aw_not_before_hs", {S0_AWVALID, S1_AWVALID, SD_AWVALID}, 64'd0);
        @(posedge clk); #1;
        I_Valid = 1'b0;
        chk("awvalid_one_cycle_after_hs", sel_awvalid(s), 1);
        chk("i_ready_low_after_hs", I_Ready, 0);
    endtask

    task automatic send_w(input int m, input logic [31:0] data, input logic [3:0] strb,
                          input logic wlast, input int s, input logic exp_last);
        logic ok;
        push_w(s, data, strb, exp_last);
        if (m == 0) begin
            M0_WDATA = data; M0_WSTRB = strb; M0_WLAST = wlast; M0_WVALID = 1'b1;
        end else begin
            M1_WDATA = data; M1_WSTRB = strb; M1_WLAST = wlast; M1_WVALID = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((m == 0) ? M0_WREADY : M1_WREADY) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL w_accept_timeout: master %0d WREADY=0 required 1", m);
        end else begin
            chk("other_master_wready_low", (m == 0) ? M1_WREADY : M0_WREADY, 0);
            @(posedge clk); #1;
        end
        if (m == 0) begin M0_WVALID = 1'b0; M0_WLAST = 1'b0; end
        else        begin M1_WVALID = 1'b0; M1_WLAST = 1'b0; end
    endtask

    initial begin
        rst = 1'b1;
        I_IDS = '0; I_Addr = '0; I_Len = '0; I_Size = '0; I_Burst = '0; I_Valid = 1'b0;
        M0_WDATA = '0; M0_WSTRB = '0; M0_WLAST = 1'b0; M0_WVALID = 1'b0;
        M1_WDATA = '0; M1_WSTRB = '0; M1_WLAST = 1'b0; M1_WVALID = 1'b0;
        S0_AWREADY = 1'b1; S1_AWREADY = 1'b1; SD_AWREADY = 1'b1;
        S0_WREADY  = 1'b1; S1_WREADY  = 1'b1; SD_WREADY  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_ready", I_Ready, 0);
        chk("rst_awvalids", {S0_AWVALID, S1_AWVALID, SD_AWVALID}, 64'd0);
        chk("rst_wvalids", {S0_WVALID, S1_WVALID, SD_WVALID}, 64'd0);
        chk("rst_wreadys", {M0_WREADY, M1_WREADY}, 64'd0);
        chk("rst_err_wlast", err_wlast, 0);
        chk("rst_s0_awaddr", S0_AWADDR, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: S0, Len=3, master 0, WLAST on beat 4
        send_aw(8'h03, 32'h0000_0040, 4'd3, 3'd2, 2'd1, 0);
        for (int i = 0; i < 4; i++)
            send_w(0, 32'h1000_0000 + i, 4'hF, (i == 3), 0, (i == 3));
        chk("t1_err_wlast", err_wlast, 0);
        chk("t1_idle_after_burst", I_Ready, 1);

        // 2: S1, Len=0, master 1; master 0 keeps WVALID high and must stay stalled
        M0_WDATA = 32'h5555_5555; M0_WSTRB = 4'hF; M0_WVALID = 1'b1;
        send_aw(8'h12, 32'h0001_0010, 4'd0, 3'd2, 2'd1, 1);
        send_w(1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 1'b1);
        chk("t2_m0_wready", M0_WREADY, 0);
        M0_WVALID = 1'b0;
        chk("t2_idle_after_burst", I_Ready, 1);

        // 3: unmapped region -> SD, Len=1, size 1, WRAP burst
        send_aw(8'h05, 32'h8000_0000, 4'd1, 3'd1, 2'd2, 2);
        send_w(0, 32'hA5A5_0001, 4'h3, 1'b0, 2, 1'b0);
        send_w(0, 32'hA5A5_0002, 4'hC, 1'b1, 2, 1'b1);

        // 4: S0_AWREADY held low 5 cycles while master 0 offers W
        S0_AWREADY = 1'b0;
        send_aw(8'h01, 32'h0000_0100, 4'd1, 3'd2, 2'd1, 0);
        M0_WDATA = 32'h7777_0000; M0_WSTRB = 4'hF; M0_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_awvalid_held", S0_AWVALID, 1);
            chk("t4_awaddr_stable", {S0_AWID, S0_AWADDR, S0_AWLEN}, {8'h01, 32'h0000_0100, 4'd1});
            chk("t4_i_ready_low", I_Ready, 0);
            chk("t4_no_w_before_aw", {M0_WREADY, S0_WVALID}, 64'd0);
        end
        @(posedge clk); #1;
        M0_WVALID = 1'b0;
        S0_AWREADY = 1'b1;
        send_w(0, 32'h7777_0001, 4'hF, 1'b0, 0, 1'b0);
        send_w(0, 32'h7777_0002, 4'hF, 1'b1, 0, 1'b1);

        // 5: early master WLAST on beat 2 -> sticky error, routed WLAST still on beat 4
        send_aw(8'h02, 32'h0000_0200, 4'd3, 3'd2, 2'd1, 0);
        send_w(0, 32'hB000_0000, 4'hF, 1'b0, 0, 1'b0);
        chk("t5_err_before", err_wlast, 0);
        send_w(0, 32'hB000_0001, 4'hF, 1'b1, 0, 1'b0);
        chk("t5_err_after_beat2", err_wlast, 1);
        send_w(0, 32'hB000_0002, 4'hF, 1'b0, 0, 1'b0);
        send_w(0, 32'hB000_0003, 4'hF, 1'b0, 0, 1'b1);
        send_aw(8'h04, 32'h0000_0300, 4'd0, 3'd2, 2'd1, 0);
        send_w(0, 32'hB000_0010, 4'hF, 1'b1, 0, 1'b1);
        chk("t5_err_sticky", err_wlast, 1);

        // 6: reset during beat 2 of a Len=7 burst; master field 3 maps to master 1
        send_aw(8'h30, 32'h0001_0000, 4'd7, 3'd2, 2'd1, 1);
        send_w(1, 32'hC000_0000, 4'hF, 1'b0, 1, 1'b0);
        M1_WDATA = 32'hC000_0001; M1_WSTRB = 4'hF; M1_WVALID = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_wvalids", {S0_WVALID, S1_WVALID, SD_WVALID}, 64'd0);
        chk("t6_rst_wreadys", {M0_WREADY, M1_WREADY}, 64'd0);
        chk("t6_rst_i_ready", I_Ready, 0);
        chk("t6_rst_err_clear", err_wlast, 0);
        @(posedge clk); #1;
        M1_WVALID = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_aw(8'h07, 32'hFFFF_0000, 4'd0, 3'd2, 2'd1, 2);
        send_w(0, 32'hD000_0000, 4'hF, 1'b1, 2, 1'b1);
        chk("t6_err_after", err_wlast, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("aw_queue_drained", aw_q.size(), 0);
        chk("w_queue_drained", w_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
